// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// dispatch_pkg : opcode defaults, unit indices, error codes and FSM encoding
// Revision     : 1.0
// ============================================================================
package dispatch_pkg;

  localparam int         NUM_UNITS      = 4;

  localparam logic [7:0] OPC_LOAD_DEF   = 8'h04;
  localparam logic [7:0] OPC_CONV_DEF   = 8'h81;
  localparam logic [7:0] OPC_DWCONV_DEF = 8'h82;
  localparam logic [7:0] OPC_STORE_DEF  = 8'h08;
  localparam logic [7:0] OPC_HALT_DEF   = 8'hFF;

  localparam logic [1:0] UNIT_LOAD      = 2'd0;
  localparam logic [1:0] UNIT_CONV      = 2'd1;
  localparam logic [1:0] UNIT_DWCONV    = 2'd2;
  localparam logic [1:0] UNIT_STORE     = 2'd3;

  localparam logic [1:0] ERRC_NONE      = 2'd0;
  localparam logic [1:0] ERRC_ILLEGAL   = 2'd1;
  localparam logic [1:0] ERRC_TIMEOUT   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_DEC   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
// dispatch_scoreboard : per-unit busy bits and completion timeout counter
// Revision            : 1.0
// ============================================================================
module dispatch_scoreboard
  import dispatch_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] set,
  input  logic [NUM_UNITS-1:0] done,
  output logic [NUM_UNITS-1:0] busy,
  output logic                 timeout
);

  logic [NUM_UNITS-1:0] r_busy;
  logic [15:0]          r_cnt;
  logic                 w_done_hit;

  // Only completions of units actually in flight count; stray pulses are dropped.
  assign w_done_hit = |(done & r_busy);
  assign timeout    = (TIMEOUT != 16'd0) && (r_cnt == TIMEOUT);
  assign busy       = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= 16'd0;
    end else begin
      // Done is applied before set so a same-cycle restart of a unit is legal.
      r_busy <= (r_busy & ~done) | set;
      if ((r_busy == '0) || w_done_hit) begin
        r_cnt <= 16'd0;
      end else if (!timeout) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_dispatch.sv
`default_nettype none
// ============================================================================
// instr_dispatch : reads instructions from a FIFO and issues them to 4 units
//                  (DISPATCH_OVERLAP_EN allows reading ahead of completion)
// Revision       : 1.0
// ============================================================================
module instr_dispatch
  import dispatch_pkg::*;
#(
  parameter logic [7:0]  OPC_LOAD   = OPC_LOAD_DEF,
  parameter logic [7:0]  OPC_CONV   = OPC_CONV_DEF,
  parameter logic [7:0]  OPC_DWCONV = OPC_DWCONV_DEF,
  parameter logic [7:0]  OPC_STORE  = OPC_STORE_DEF,
  parameter logic [7:0]  OPC_HALT   = OPC_HALT_DEF,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [63:0] fifo_dout,
  output logic [3:0]  unit_start,
  output logic [63:0] unit_instr,
  input  logic [3:0]  unit_done,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] issued_cnt
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  w_opc;
  logic [1:0]  w_dec_unit, r_unit;
  logic        w_dec_known, w_fire, w_next_ok, w_timeout, w_unit_free;
  logic [3:0]  w_busy, w_set, r_start;
  logic [1:0]  r_err_code;
  logic [63:0] r_instr;
  logic [15:0] r_issued;

  assign w_opc = fifo_dout[63:56];

  always_comb begin
    w_dec_known = 1'b1;
    w_dec_unit  = UNIT_LOAD;
    if (w_opc == OPC_LOAD)        w_dec_unit = UNIT_LOAD;
    else if (w_opc == OPC_CONV)   w_dec_unit = UNIT_CONV;
    else if (w_opc == OPC_DWCONV) w_dec_unit = UNIT_DWCONV;
    else if (w_opc == OPC_STORE)  w_dec_unit = UNIT_STORE;
    else                          w_dec_known = 1'b0;
  end

`ifdef DISPATCH_OVERLAP_EN
  // By WAIT the previous start has been pulsed, so the next read may proceed.
  assign w_next_ok = 1'b1;
`else
  assign w_next_ok = (w_busy == 4'b0000);
`endif

  assign w_unit_free = !w_busy[r_unit] || unit_done[r_unit];

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE:  if (enable && !fifo_empty) w_state_nxt = ST_RD;
      ST_RD:    w_state_nxt = ST_DEC;
      ST_DEC: begin
        if (w_opc == OPC_HALT) w_state_nxt = ST_HALT;
        else if (w_dec_known)  w_state_nxt = ST_ISSUE;
        else                   w_state_nxt = ST_ERR;
      end
      ST_ISSUE: begin
        if (w_unit_free) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT:  if (w_next_ok && !fifo_empty) w_state_nxt = ST_RD;
      ST_HALT:  w_state_nxt = ST_HALT;
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // A stuck unit overrides everything, including a pending issue.
    if (w_timeout && (r_state != ST_ERR)) begin
      w_state_nxt = ST_ERR;
      w_fire      = 1'b0;
    end
  end

  assign w_set = w_fire ? (4'b0001 << r_unit) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_unit     <= UNIT_LOAD;
      r_start    <= 4'b0000;
      r_err_code <= ERRC_NONE;
      r_instr    <= 64'd0;
      r_issued   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_set;
      if (w_fire) r_issued <= r_issued + 16'd1;
      if (r_state == ST_DEC) begin
        r_instr <= fifo_dout;
        r_unit  <= w_dec_unit;
      end
      if ((r_state != ST_ERR) && (w_state_nxt == ST_ERR)) begin
        r_err_code <= w_timeout ? ERRC_TIMEOUT : ERRC_ILLEGAL;
      end
    end
  end

  dispatch_scoreboard #(
    .TIMEOUT (TIMEOUT)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set     (w_set),
    .done    (unit_done),
    .busy    (w_busy),
    .timeout (w_timeout)
  );

  assign fifo_rd_en = (r_state == ST_RD);
  assign unit_start = r_start;
  assign unit_instr = r_instr;
  assign halted     = (r_state == ST_HALT) && (w_busy == 4'b0000);
  assign err        = (r_state == ST_ERR);
  assign err_code   = r_err_code;
  assign issued_cnt = r_issued;

endmodule
`default_nettype wire
